fetch_sequencer: RTL and testbench

Instruction fetch controller for NECPU. Owns the program counter, drives the word address into the combinational instruction memory (`instMem`), and captures each returned instruction with its PC into a small in-order buffer. The buffer presents instructions to decode over a valid/ready handshake. Execute can redirect the PC for branches and jumps, which flushes the buffer.

---
 rtl/necpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 91 +++++++++
 rtl/fetch_sequencer.sv | 82 ++++++++
 tb/tb_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/necpu_pkg.sv
// Shared NECPU definitions.
// Purpose: common widths, the NOP encoding and the fetch buffer entry type
// used by the fetch sequencer and its buffer.
package necpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'd0;

    // One fetched instruction together with the word address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small in-order instruction buffer with flush.
// Purpose: holds {pc, inst} pairs between fetch and decode.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   push_i             write wr_pc_i/wr_inst_i at the tail
//   pop_i              advance the head (ignored when empty)
//   flush_i            discard every entry; wins over push and pop
//   wr_pc_i, wr_inst_i entry written on push
//   full_o, empty_o    occupancy flags
//   head_pc_o          head word address, zero when empty
//   head_inst_o        head instruction, NOP when empty
module fetch_fifo
    import necpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic [XLEN-1:0] wr_inst_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_inst_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic pop_ok;
    logic push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // A push into a full buffer is legal only when the head leaves in the
    // same cycle, so occupancy stays at DEPTH.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= '{pc: wr_pc_i, inst: wr_inst_i};
        end
    end

    assign head_pc_o   = empty_o ? '0       : mem_q[rd_ptr_q].pc;
    assign head_inst_o = empty_o ? NOP_INST : mem_q[rd_ptr_q].inst;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: NECPU instruction fetch controller.
// Purpose: owns the PC, addresses the combinational instruction memory and
// queues each returned instruction with its PC for decode. A redirect from
// execute flushes the queue and reloads the PC.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   fetch_en         allow fetching; PC frozen when low
//   imem_addr        word address to instMem (the PC register)
//   imem_inst        instruction returned for imem_addr
//   redirect_valid   branch/jump taken this cycle
//   redirect_pc      target word address
//   out_valid/ready  handshake to decode: transfer when both are 1
//                    in the same cycle; out_valid never depends on
//                    out_ready, and out_inst/out_pc hold while stalled
//   out_inst/out_pc  head instruction and its address, zero when empty
module fetch_sequencer
    import necpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    // Redirect suppresses the push: the instruction at the old PC is stale.
    assign push = fetch_en & ~redirect_valid & (~fifo_full | pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .wr_pc_i     (pc_q),
        .wr_inst_i   (imem_inst),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_pc_o   (out_pc),
        .head_inst_o (out_inst)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'd0;
    localparam int          N_RAND   = 3000;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int n_checks;
    int n_errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    // Instruction memory contents: word 0 is 32'd268468224 (0x10008000).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_8000 ^ (a * 32'h9E37_79B1);
    endfunction

    assign imem_inst = mem_word(imem_addr);

    // ---------------- reference model ----------------
    // Buffer contents as {pc, inst}, head at index 0; m_pc is the fetch PC.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;

    task automatic model_edge(input logic rst, input logic fe, input logic rv,
                              input logic [31:0] rpc, input logic rdy);
        bit do_pop;
        bit do_push;
        if (!rst) begin
            exp_q.delete();
            m_pc = RESET_PC;
        end else begin
            do_pop  = (exp_q.size() > 0) && rdy;
            do_push = fe && !rv && ((exp_q.size() < DEPTH) || do_pop);
            if (do_pop) void'(exp_q.pop_front());
            if (rv) begin
                exp_q.delete();
                m_pc = rpc;
            end else if (do_push) begin
                exp_q.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_pc   = (exp_q.size() > 0) ? exp_q[0][63:32] : 32'd0;
        e_inst = (exp_q.size() > 0) ? exp_q[0][31:0]  : 32'd0;
        chk({tag, " out_valid"}, {31'd0, out_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
        chk({tag, " out_pc"},    out_pc,    e_pc);
        chk({tag, " out_inst"},  out_inst,  e_inst);
        chk({tag, " imem_addr"}, imem_addr, m_pc);
    endtask

    // ---------------- driver ----------------
    // Inputs change right after a falling edge; outputs are sampled at the
    // next falling edge, half a cycle after the rising edge.
    task automatic step(input logic rst, input logic fe, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        rst_n          = rst;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        model_edge(rst, fe, rv, rpc, rdy);
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic fe, input logic rv,
                                input logic [31:0] rpc, input logic rdy,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] ea);
        vec_t v;
        v.rst = rst; v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_addr = ea;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; out_ready = 1'b0;

        //                rst fe rv rpc            rdy  valid pc            addr
        // streaming with decode always ready
        vecs.push_back(mk(0, 1, 0, 32'd0,          1,   0, 32'd0,          32'd0));
        vecs.push_back(mk(1, 1, 0, 32'd0,          1,   1, 32'd0,          32'd1));
        vecs.push_back(mk(1, 1, 0, 32'd0,          1,   1, 32'd1,          32'd2));
        vecs.push_back(mk(1, 1, 0, 32'd0,          1,   1, 32'd2,          32'd3));
        // reset, then decode stalls five cycles: buffer fills, PC stalls at 2
        vecs.push_back(mk(0, 1, 0, 32'd0,          0,   0, 32'd0,          32'd0));
        vecs.push_back(mk(1, 1, 0, 32'd0,          0,   1, 32'd0,          32'd1));
        vecs.push_back(mk(1, 1, 0, 32'd0,          0,   1, 32'd0,          32'd2));
        vecs.push_back(mk(1, 1, 0, 32'd0,          0,   1, 32'd0,          32'd2));
        vecs.push_back(mk(1, 1, 0, 32'd0,          0,   1, 32'd0,          32'd2));
        vecs.push_back(mk(1, 1, 0, 32'd0,          0,   1, 32'd0,          32'd2));
        // release: full buffer pushes while popping
        vecs.push_back(mk(1, 1, 0, 32'd0,          1,   1, 32'd1,          32'd3));
        vecs.push_back(mk(1, 1, 0, 32'd0,          1,   1, 32'd2,          32'd4));
        vecs.push_back(mk(1, 1, 0, 32'd0,          0,   1, 32'd2,          32'd4));
        vecs.push_back(mk(1, 1, 0, 32'd0,          1,   1, 32'd3,          32'd5));
        // buffer holds 3,4: redirect to 8 flushes both
        vecs.push_back(mk(1, 1, 1, 32'd8,          0,   0, 32'd0,          32'd8));
        vecs.push_back(mk(1, 1, 0, 32'd0,          1,   1, 32'd8,          32'd9));
        vecs.push_back(mk(1, 1, 0, 32'd0,          1,   1, 32'd9,          32'd10));
        // redirect during a head transfer, to the top of the address space
        vecs.push_back(mk(1, 1, 1, 32'hFFFF_FFFF,  1,   0, 32'd0,          32'hFFFF_FFFF));
        vecs.push_back(mk(1, 1, 0, 32'd0,          1,   1, 32'hFFFF_FFFF,  32'd0));
        vecs.push_back(mk(1, 1, 0, 32'd0,          1,   1, 32'd0,          32'd1));
        // fetch disabled: PC frozen, pops still drain
        vecs.push_back(mk(1, 0, 0, 32'd0,          0,   1, 32'd0,          32'd1));
        vecs.push_back(mk(1, 0, 0, 32'd0,          1,   0, 32'd0,          32'd1));
        vecs.push_back(mk(1, 1, 0, 32'd0,          0,   1, 32'd1,          32'd2));
        vecs.push_back(mk(1, 1, 0, 32'd0,          0,   1, 32'd1,          32'd3));
        // reset with a full buffer
        vecs.push_back(mk(0, 1, 0, 32'd0,          1,   0, 32'd0,          RESET_PC));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d out_inst", i), out_inst,
                vecs[i].e_valid ? mem_word(vecs[i].e_pc) : 32'd0);
            chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
        end

        // hand sequence: first fetch after reset returns memory word 0
        step(0, 1, 0, 32'd0, 0);
        step(1, 1, 0, 32'd0, 0);
        chk("first_inst", out_inst, 32'd268468224);
        chk("first_pc", out_pc, 32'd0);

        // hand sequence: outputs hold stable while decode stalls on a full buffer
        step(1, 1, 0, 32'd0, 0);
        step(1, 1, 0, 32'd0, 0);
        chk("stall_pc", out_pc, 32'd0);
        chk("stall_addr", imem_addr, 32'd2);
        chk_model("stall");

        // randomized phase against the model
        for (int c = 0; c < N_RAND; c++) begin
            logic        r_rst;
            logic        r_fe;
            logic        r_rv;
            logic        r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 99) != 0);
            r_fe  = ($urandom_range(0, 99) < 85);
            r_rv  = ($urandom_range(0, 99) < 6);
            r_rdy = ($urandom_range(0, 99) < 65);
            case ($urandom_range(0, 2))
                0:       r_pc = $urandom_range(0, 63);
                1:       r_pc = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: r_pc = $urandom;
            endcase
            step(r_rst, r_fe, r_rv, r_pc, r_rdy);
            chk_model($sformatf("rand%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
